// File: rtl/uart_axi_stream_bridge.sv
// AXI4-Lite master that configures a UART IP once, then polls its status and moves bytes
// between the UART FIFOs and two byte streams. Optional IRQ wake-up: UART_BRIDGE_IRQ_WAKE_EN.
module uart_axi_stream_bridge #(
  parameter int          UART_BASE_ADDR     = 0,
  parameter int          C_M_AXI_ADDR_WIDTH = 5,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] INIT_CONFIG        = 32'h0000_6285,
  parameter int          POLL_INTERVAL      = 64
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [7:0]                    tx_tdata,
  input  logic                          tx_tvalid,
  output logic                          tx_tready,
  output logic [7:0]                    rx_tdata,
  output logic [1:0]                    rx_tuser,
  output logic                          rx_tvalid,
  input  logic                          rx_tready,
  input  logic                          uart_irq,
  output logic [3:0]                    err_status,
  input  logic                          err_clear,
  output logic [3:0]                    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a source never drops valid or changes its payload before that edge.

  typedef enum logic [3:0] {
    INIT_WR, INIT_B, IDLE, STAT_AR, STAT_R, RX_AR, RX_R, TX_WR, TX_B
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_RX   = C_M_AXI_ADDR_WIDTH'(UART_BASE_ADDR);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_TX   = C_M_AXI_ADDR_WIDTH'(UART_BASE_ADDR + 4);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_CFG  = C_M_AXI_ADDR_WIDTH'(UART_BASE_ADDR + 8);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STAT = C_M_AXI_ADDR_WIDTH'(UART_BASE_ADDR + 12);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] poll_cnt;
  logic             aw_done, w_done;
  logic             aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic             wr_phase, ar_phase;
  logic             irq_wake;
  logic             tx_take;
  logic [3:0]       err_set;
  logic             unused_ok;

  assign aw_fire  = m_axi_awvalid & m_axi_awready;
  assign w_fire   = m_axi_wvalid & m_axi_wready;
  assign b_fire   = m_axi_bvalid & m_axi_bready;
  assign ar_fire  = m_axi_arvalid & m_axi_arready;
  assign r_fire   = m_axi_rvalid & m_axi_rready;
  assign wr_phase = (state == INIT_WR) || (state == TX_WR);
  assign ar_phase = (state == STAT_AR) || (state == RX_AR);

  assign m_axi_bready = (state == INIT_B) || (state == TX_B);
  assign m_axi_rready = (state == STAT_R) || (state == RX_R);
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;
  assign dbg_state    = state;

`ifdef UART_BRIDGE_IRQ_WAKE_EN
  assign irq_wake = uart_irq;
`else
  assign irq_wake = 1'b0;
`endif

  assign unused_ok = &{1'b0, uart_irq, m_axi_rdata[C_M_AXI_DATA_WIDTH-1:10]};

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= INIT_WR;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 4'b0000;
    case (state)
      INIT_WR, TX_WR: begin
        if ((aw_done || aw_fire) && (w_done || w_fire))
          state_nxt = (state == INIT_WR) ? INIT_B : TX_B;
      end
      INIT_B: begin
        if (b_fire) begin
          err_set[3] = (m_axi_bresp != RESP_OKAY);
          state_nxt  = IDLE;
        end
      end
      IDLE: begin
        if (irq_wake || (poll_cnt == POLL_LAST)) state_nxt = STAT_AR;
      end
      STAT_AR: if (ar_fire) state_nxt = STAT_R;
      STAT_R: begin
        if (r_fire) begin
          // Error flags clear on read in the UART, so they are folded in here every time.
          err_set[2:0] = m_axi_rdata[6:4];
          if (!m_axi_rdata[0] && !rx_tvalid)     state_nxt = RX_AR;
          else if (tx_tvalid && !m_axi_rdata[3]) state_nxt = TX_WR;
          else                                   state_nxt = IDLE;
        end
      end
      RX_AR: if (ar_fire) state_nxt = RX_R;
      RX_R: begin
        if (r_fire) begin
          err_set[3] = (m_axi_rresp != RESP_OKAY);
          state_nxt  = STAT_AR;
        end
      end
      TX_B: begin
        if (b_fire) begin
          err_set[3] = (m_axi_bresp != RESP_OKAY);
          state_nxt  = STAT_AR;
        end
      end
      default: state_nxt = INIT_WR;
    endcase
  end

  assign tx_take = (state == STAT_R) && (state_nxt == TX_WR);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      poll_cnt      <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      tx_tready     <= 1'b0;
      rx_tvalid     <= 1'b0;
      rx_tdata      <= 8'h00;
      rx_tuser      <= 2'b00;
      err_status    <= 4'b0000;
    end else begin
      if (state == IDLE)
        poll_cnt <= (state_nxt != IDLE) ? '0 : poll_cnt + CNT_W'(1);

      // AW and W start together but complete independently.
      if (wr_phase) begin
        if (aw_fire) begin
          m_axi_awvalid <= 1'b0;
          aw_done       <= 1'b1;
        end else if (!m_axi_awvalid && !aw_done) begin
          m_axi_awvalid <= 1'b1;
          m_axi_awaddr  <= (state == INIT_WR) ? ADDR_CFG : ADDR_TX;
        end
        if (w_fire) begin
          m_axi_wvalid <= 1'b0;
          w_done       <= 1'b1;
        end else if (!m_axi_wvalid && !w_done) begin
          m_axi_wvalid <= 1'b1;
          m_axi_wdata  <= (state == INIT_WR) ? C_M_AXI_DATA_WIDTH'(INIT_CONFIG)
                                             : {{(C_M_AXI_DATA_WIDTH-8){1'b0}}, tx_tdata};
        end
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      // tx_tready is high on the first TX_WR cycle, the same cycle wdata takes the byte.
      tx_tready <= tx_take;

      if (ar_phase) begin
        if (ar_fire) begin
          m_axi_arvalid <= 1'b0;
        end else if (!m_axi_arvalid) begin
          m_axi_arvalid <= 1'b1;
          m_axi_araddr  <= (state == STAT_AR) ? ADDR_STAT : ADDR_RX;
        end
      end

      if (rx_tvalid && rx_tready) rx_tvalid <= 1'b0;
      if ((state == RX_R) && r_fire && (m_axi_rresp == RESP_OKAY)) begin
        rx_tvalid <= 1'b1;
        rx_tdata  <= m_axi_rdata[7:0];
        rx_tuser  <= m_axi_rdata[9:8];
      end

      err_status <= err_clear ? 4'b0000 : (err_status | err_set);
    end
  end

endmodule

// File: doc/uart_axi_stream_bridge.md
Name: uart_axi_stream_bridge

Overview:
AXI4-Lite master that sits directly in front of the UART transceiver IP's AXI-lite slave port and exposes it as two byte streams.
- Once after reset, writes a configuration word.
- Then polls the status register and moves bytes in both directions:
  - RX FIFO to an AXI-Stream-style output.
  - AXI-Stream-style input to the TX FIFO.
- Lets stream-based logic use the UART without a processor.

Parameters:
UART_BASE_ADDR, 0, base address of the UART slave; added to every register offset.
C_M_AXI_ADDR_WIDTH, 5, AXI address width.
C_M_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
INIT_CONFIG, 32'h0000_6285, value written to CONFIG (offset 8) after reset: Rx-irq, errbuf, 460.8k base, div 2, 8-bit, irq enable.
POLL_INTERVAL, 64, idle cycles between status polls; minimum 1.

Ports:
m_axi_aclk  in  1  clock
m_axi_aresetn  in  1  reset, asynchronous, active-low
m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH  write address
m_axi_awprot  out  3  constant 3'b000
m_axi_awvalid/m_axi_awready  out/in  1  write-address handshake
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  constant 4'hF
m_axi_wvalid/m_axi_wready  out/in  1  write-data handshake
m_axi_bresp  in  2  write response
m_axi_bvalid/m_axi_bready  in/out  1  write-response handshake
m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  read address
m_axi_arprot  out  3  constant 3'b000
m_axi_arvalid/m_axi_arready  out/in  1  read-address handshake
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rvalid/m_axi_rready  in/out  1  read-data handshake
tx_tdata  in  8  byte to transmit
tx_tvalid/tx_tready  in/out  1  TX stream handshake
rx_tdata  out  8  received byte
rx_tuser  out  2  {parity_err, frame_err} for this byte
rx_tvalid/rx_tready  out/in  1  RX stream handshake
uart_irq  in  1  interrupt output of the UART IP
err_status  out  4  sticky {bus_err, overrun, parity, frame}
err_clear  in  1  clears err_status, one-cycle pulse

Behaviour:
- Clock and reset: one clock, m_axi_aclk. Reset m_axi_aresetn is asynchronous and active-low.
- Reset values:
  - All valid/ready outputs 0.
  - Addresses and wdata 0; rx_tdata/rx_tuser 0; err_status 0.
  - Poll counter 0; FSM in INIT.
  - Assertion mid-transaction abandons the transaction immediately; no completion is attempted.
- FSM states: INIT_WR, INIT_B, IDLE, STAT_AR, STAT_R, RX_AR, RX_R, TX_WR, TX_B.
- Write phase (INIT_WR, TX_WR):
  - awvalid and wvalid are asserted together in the same cycle.
  - Each one drops independently on its own ready; track aw_done and w_done.
  - Move to *_B when both are done. bready is 1 only in *_B.
- Read phase (*_AR): arvalid is held until arready. rready is 1 only in *_R.
- Stability: address and data stay stable while valid is high.
- INIT_WR / INIT_B: write INIT_CONFIG to base+8. INIT_B goes to IDLE regardless of bresp; bresp!=OKAY sets bus_err.
- IDLE:
  - Poll counter increments each cycle.
  - At POLL_INTERVAL-1, clear the counter and go to STAT_AR (read base+12).
- STAT_R, on rvalid: latch status bits.
  - Set err_status[2:0] |= rdata[6:4]; the UART clears these bits on read.
  - Priority 1: if rdata[0]==0 (RX not empty) and the RX output register is empty, go to RX_AR.
  - Priority 2: else if tx_tvalid and rdata[3]==0 (TX not full), go to TX_WR.
  - Otherwise go to IDLE.
- RX_AR / RX_R: read base+0.
  - On rvalid with rresp==OKAY: rx_tdata=rdata[7:0], rx_tuser=rdata[9:8], rx_tvalid=1.
  - On SLVERR: discard the data and set bus_err.
  - Then return to STAT_AR with no idle wait, so bursts drain back-to-back.
- TX_WR: wdata={24'b0,tx_tdata} to base+4.
  - tx_tready pulses for exactly 1 cycle on the cycle the FSM enters TX_WR; the byte is captured into the wdata register.
  - In TX_B, SLVERR (FIFO full) sets bus_err and the byte is lost. Then go to STAT_AR.
- RX output register: one entry. rx_tvalid holds until rx_tready; it clears on the handshake cycle. STAT_R does not choose RX_AR while it is occupied.
- err_status is sticky. err_clear has priority over a same-cycle set.
- Status is always re-read before each data transfer; RX_BUFF is never read blind.

Optional Feature:
UART_BRIDGE_IRQ_WAKE_EN.
- Defined: in IDLE, uart_irq==1 sampled high ends the wait immediately and goes to STAT_AR; the poll counter is cleared.
- Not defined: uart_irq is ignored, polling is purely timer-based, and the port remains present but unused.

Test Plan:
Reset release -> first AW/W transaction is addr 8, data 0x00006285, wstrb 4'hF; FSM reaches IDLE after the B handshake.
Slave status 0x82 (RX not empty), RX_BUFF 0x0000_0141 -> rx_tdata=0x41, rx_tuser=2'b01, rx_tvalid=1 until rx_tready; next status read follows with no idle gap.
tx_tvalid with tx_tdata=0x5A, status 0x01 -> write addr 4, data 0x5A; tx_tready high for exactly 1 cycle.
Status 0x09 (TX full) with tx_tvalid=1 -> no write issued, tx_tready stays 0, FSM returns to IDLE; then status 0x01 -> write issued.
Status 0x70, then a TX bresp=2'b10 -> err_status=4'b1111; err_clear pulse -> 4'b0000.
awready delayed 3 cycles after wready, plus reset asserted during RX_R -> outputs return to 0 asynchronously; INIT config write re-issued after release.
